aes128_decrypt_iter: RTL and testbench

- Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It is the decrypt counterpart of the existing encrypt round functions.
- It accepts a 128-bit ciphertext and the final (round-10) round key, and returns the plaintext after 10 round cycles.
- It derives round keys 9..0 on the fly using the reverse key schedule, so no key RAM is needed.
- It sits beside the encrypt datapath and shares its S-box and byte-ordering conventions.

---
 rtl/aes_pkg.sv | 73 +++++++
 rtl/aes128_decrypt_iter_if.sv | 26 ++
 rtl/aes_sbox.sv | 15 +
 rtl/inv_sbox.sv | 14 +
 rtl/aes128_decrypt_iter.sv | 136 +++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 339 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round constants, FSM encodings and the
// GF(2^8) helpers used by the encrypt and decrypt round logic.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    // Round constant indexed by round number; entries 11..15 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // General product, shift-and-add with xtime.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

endpackage

// File: rtl/aes128_decrypt_iter_if.sv
// Request/response bundle of the iterative AES-128 decryptor.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender keeps its payload stable while valid waits for ready.
interface aes128_decrypt_iter_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] ct;
    logic [AES_KEY_W-1:0]   key_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] pt;
    logic                   busy;

    modport master (
        output in_valid, ct, key_last, out_ready,
        input  in_ready, out_valid, pt, busy
    );

    modport slave (
        input  in_valid, ct, key_last, out_ready,
        output in_ready, out_valid, pt, busy
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^
                    rotl8(w_inv, 3) ^ rotl8(w_inv, 4) ^ 8'h63;

endmodule

// File: rtl/inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by GF(2^8) inverse.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_pre;

    assign w_pre  = rotl8(i_byte, 1) ^ rotl8(i_byte, 3) ^ rotl8(i_byte, 6) ^ 8'h05;
    assign o_byte = gf_inv(w_pre);

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per cycle, round keys derived
// backwards from the round-10 key so no key storage is needed.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
)
(
    input  logic                  clk,
    input  logic                  rst,
    aes128_decrypt_iter_if.slave  io_dec,
    output aes_state_e            o_dbg_state,
    output logic [3:0]            o_dbg_rnd,
    output logic [AES_KEY_W-1:0]  o_dbg_key
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes128_decrypt_iter supports only NUM_ROUNDS = 10");
    end

    aes_state_e             r_state;
    aes_state_e             w_next_state;
    logic                   w_accept;
    logic [AES_BLOCK_W-1:0] r_state_blk;
    logic [AES_KEY_W-1:0]   r_key;
    logic [3:0]             r_rnd;
    logic [AES_BLOCK_W-1:0] r_pt;

    // Reverse key schedule: previous round key from the current one.
    logic [31:0]            w_kp_w3, w_kp_w2, w_kp_w1, w_kp_w0;
    logic [31:0]            w_rot, w_sub;
    logic [AES_KEY_W-1:0]   w_kp;

    assign w_kp_w3 = r_key[127:96] ^ r_key[95:64];
    assign w_kp_w2 = r_key[95:64]  ^ r_key[63:32];
    assign w_kp_w1 = r_key[63:32]  ^ r_key[31:0];
    assign w_rot   = {w_kp_w3[7:0], w_kp_w3[31:8]};
    assign w_kp_w0 = r_key[31:0] ^ w_sub ^ {24'd0, RCON[r_rnd]};
    assign w_kp    = {w_kp_w3, w_kp_w2, w_kp_w1, w_kp_w0};

    for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
        aes_sbox u_sbox (.i_byte(w_rot[8*gi +: 8]), .o_byte(w_sub[8*gi +: 8]));
    end

    // State path: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    logic [AES_BLOCK_W-1:0] w_shift, w_isub, w_addkey, w_mix;

    // InvShiftRows: row r rotates right by r columns.
    always_comb begin
        w_shift = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[8*(r+4*c) +: 8] = r_state_blk[8*(r+4*((c-r+4)%4)) +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sbox
        inv_sbox u_isbox (.i_byte(w_shift[8*gi +: 8]), .o_byte(w_isub[8*gi +: 8]));
    end

    assign w_addkey = w_isub ^ w_kp;

    // InvMixColumns on each column of the key-added state.
    always_comb begin
        w_mix = '0;
        for (int c = 0; c < 4; c++) begin
            w_mix[8*(4*c)   +: 8] = gf_mul0e(w_addkey[8*(4*c) +: 8])   ^ gf_mul0b(w_addkey[8*(4*c+1) +: 8]) ^
                                    gf_mul0d(w_addkey[8*(4*c+2) +: 8]) ^ gf_mul09(w_addkey[8*(4*c+3) +: 8]);
            w_mix[8*(4*c+1) +: 8] = gf_mul09(w_addkey[8*(4*c) +: 8])   ^ gf_mul0e(w_addkey[8*(4*c+1) +: 8]) ^
                                    gf_mul0b(w_addkey[8*(4*c+2) +: 8]) ^ gf_mul0d(w_addkey[8*(4*c+3) +: 8]);
            w_mix[8*(4*c+2) +: 8] = gf_mul0d(w_addkey[8*(4*c) +: 8])   ^ gf_mul09(w_addkey[8*(4*c+1) +: 8]) ^
                                    gf_mul0e(w_addkey[8*(4*c+2) +: 8]) ^ gf_mul0b(w_addkey[8*(4*c+3) +: 8]);
            w_mix[8*(4*c+3) +: 8] = gf_mul0b(w_addkey[8*(4*c) +: 8])   ^ gf_mul0d(w_addkey[8*(4*c+1) +: 8]) ^
                                    gf_mul09(w_addkey[8*(4*c+2) +: 8]) ^ gf_mul0e(w_addkey[8*(4*c+3) +: 8]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and handshake outputs; in_ready stays low while reset is held.
    always_comb begin
        w_next_state     = r_state;
        w_accept         = 1'b0;
        io_dec.in_ready  = 1'b0;
        io_dec.out_valid = 1'b0;
        io_dec.busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_dec.in_ready = ~rst;
                if (io_dec.in_valid && !rst) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                io_dec.busy = 1'b1;
                if (r_rnd == 4'd1) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                io_dec.out_valid = 1'b1;
                if (io_dec.out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, one round per ROUND cycle, last round writes pt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_blk <= '0;
            r_key       <= '0;
            r_rnd       <= 4'd0;
            r_pt        <= '0;
        end else if (w_accept) begin
            r_state_blk <= io_dec.ct ^ io_dec.key_last;
            r_key       <= io_dec.key_last;
            r_rnd       <= 4'(NUM_ROUNDS);
        end else if (r_state == ST_ROUND) begin
            r_key <= w_kp;
            r_rnd <= r_rnd - 4'd1;
            if (r_rnd == 4'd1) r_pt        <= w_addkey;
            else               r_state_blk <= w_mix;
        end
    end

    assign io_dec.pt   = r_pt;
    assign o_dbg_state = r_state;
    assign o_dbg_rnd   = r_rnd;
    assign o_dbg_key   = r_key;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS-197 vectors, handshake corner cases and
// random blocks produced by a forward-cipher model of AES-128.
module tb_aes128_decrypt_iter;
    import aes_pkg::*;

    logic           clk;
    logic           rst;
    aes_state_e     dbg_state;
    logic [3:0]     dbg_rnd;
    logic [127:0]   dbg_key;
    int             n_checks;
    int             n_pass;
    logic [7:0]     sbox [256];

    aes128_decrypt_iter_if dec_if ();

    aes128_decrypt_iter #(.NUM_ROUNDS(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_dec      (dec_if),
        .o_dbg_state (dbg_state),
        .o_dbg_rnd   (dbg_rnd),
        .o_dbg_key   (dbg_key)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // FIPS byte string (s0 first) to bus layout (s0 at bits [7:0]).
    function automatic logic [127:0] fips(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] tb_rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] m2(input logic [7:0] a);
        logic [7:0] r;
        r = a << 1;
        if (a[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    // S-box table by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ tb_rotl(q, 1) ^ tb_rotl(q, 2) ^ tb_rotl(q, 3) ^ tb_rotl(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    // Forward AES-128: key expansion plus Cipher; returns ct and round-10 key.
    function automatic void aes_encrypt(input logic [127:0] p, input logic [127:0] key,
                                        output logic [127:0] c, output logic [127:0] rk_last);
        logic [7:0] w [44][4];
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++) w[i][b] = key[8*(4*i+b) +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int b = 0; b < 4; b++) tmp[b] = w[i-1][b];
            if (i % 4 == 0) begin
                tmp[0] = sbox[w[i-1][1]] ^ rc;
                tmp[1] = sbox[w[i-1][2]];
                tmp[2] = sbox[w[i-1][3]];
                tmp[3] = sbox[w[i-1][0]];
                rc = m2(rc);
            end
            for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ tmp[b];
        end
        for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++) s[r][cc] = p[8*(r+4*cc) +: 8] ^ w[cc][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int cc = 0; cc < 4; cc++)
                for (int r = 0; r < 4; r++) t[r][cc] = sbox[s[r][(cc+r)%4]];
            s = t;
            if (rnd < 10) begin
                for (int cc = 0; cc < 4; cc++) begin
                    a0 = s[0][cc]; a1 = s[1][cc]; a2 = s[2][cc]; a3 = s[3][cc];
                    s[0][cc] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
                    s[1][cc] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
                    s[2][cc] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
                    s[3][cc] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
                end
            end
            for (int cc = 0; cc < 4; cc++)
                for (int r = 0; r < 4; r++) s[r][cc] = s[r][cc] ^ w[4*rnd+cc][r];
        end
        for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++) begin
                c[8*(r+4*cc) +: 8]       = s[r][cc];
                rk_last[8*(r+4*cc) +: 8] = w[40+cc][r];
            end
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Driver tasks; everything happens on the falling edge.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (dec_if.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(dec_if.in_ready), 128'd1);
    endtask

    task automatic start_block(input logic [127:0] c, input logic [127:0] k);
        wait_ready("in_ready_before_start");
        dec_if.ct       = c;
        dec_if.key_last = k;
        dec_if.in_valid = 1'b1;
        @(negedge clk);
        dec_if.in_valid = 1'b0;
    endtask

    // Called on the first falling edge after accept; returns edges to out_valid.
    task automatic run_to_done(output int lat);
        int cyc;
        cyc = 1;
        while (dec_if.out_valid !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
    endtask

    task automatic consume();
        dec_if.out_ready = 1'b1;
        @(negedge clk);
        dec_if.out_ready = 1'b0;
    endtask

    logic [127:0] c1_ct, c1_key, c1_pt, c1_k0;
    logic [127:0] b_ct, b_key, b_pt, b_k0;
    logic [127:0] r_p, r_k, r_c, r_rk, pt_hold;
    int           lat, cyc, n1, n2, bp;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        build_sbox();
        c1_ct  = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        c1_key = fips(128'h13111d7fe3944a17f307a78b4d2b30c5);
        c1_pt  = fips(128'h00112233445566778899aabbccddeeff);
        c1_k0  = fips(128'h000102030405060708090a0b0c0d0e0f);
        b_ct   = fips(128'h3925841d02dc09fbdc118597196a0b32);
        b_key  = fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        b_pt   = fips(128'h3243f6a8885a308d313198a2e0370734);
        b_k0   = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);

        rst              = 1'b1;
        dec_if.in_valid  = 1'b0;
        dec_if.ct        = '0;
        dec_if.key_last  = '0;
        dec_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(dec_if.in_ready), 128'd0);
        check("rst_out_valid", 128'(dec_if.out_valid), 128'd0);
        check("rst_busy", 128'(dec_if.busy), 128'd0);
        check("rst_pt", dec_if.pt, 128'd0);
        check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        check("rst_rnd", 128'(dbg_rnd), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 128'(dec_if.in_ready), 128'd1);

        // FIPS-197 C.1
        start_block(c1_ct, c1_key);
        check("c1_busy", 128'(dec_if.busy), 128'd1);
        check("c1_in_ready_busy", 128'(dec_if.in_ready), 128'd0);
        check("c1_rnd_start", 128'(dbg_rnd), 128'd10);
        run_to_done(lat);
        check("c1_latency", 128'(lat), 128'd10);
        check("c1_pt", dec_if.pt, c1_pt);
        check("c1_done_busy", 128'(dec_if.busy), 128'd0);
        check("c1_key0", dbg_key, c1_k0);
        consume();
        check("c1_after_out_valid", 128'(dec_if.out_valid), 128'd0);
        check("c1_after_in_ready", 128'(dec_if.in_ready), 128'd1);

        // FIPS-197 Appendix B
        start_block(b_ct, b_key);
        run_to_done(lat);
        check("b_latency", 128'(lat), 128'd10);
        check("b_pt", dec_if.pt, b_pt);
        check("b_key0", dbg_key, b_k0);
        consume();

        // Back-pressure: hold DONE for 20 cycles.
        start_block(c1_ct, c1_key);
        run_to_done(lat);
        check("bp_latency", 128'(lat), 128'd10);
        pt_hold = dec_if.pt;
        check("bp_pt", pt_hold, c1_pt);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(dec_if.out_valid), 128'd1);
            check("bp_pt_stable", dec_if.pt, c1_pt);
            check("bp_in_ready", 128'(dec_if.in_ready), 128'd0);
        end
        consume();
        check("bp_release_out_valid", 128'(dec_if.out_valid), 128'd0);
        check("bp_release_in_ready", 128'(dec_if.in_ready), 128'd1);

        // in_valid pulses with a foreign block while busy are ignored.
        wait_ready("busy_in_ready");
        dec_if.ct       = c1_ct;
        dec_if.key_last = c1_key;
        dec_if.in_valid = 1'b1;
        @(negedge clk);
        dec_if.in_valid = 1'b0;
        cyc = 1;
        while (dec_if.out_valid !== 1'b1 && cyc < 64) begin
            if (cyc == 3 || cyc == 7) begin
                dec_if.in_valid = 1'b1;
                dec_if.ct       = rand128();
                dec_if.key_last = rand128();
            end else begin
                dec_if.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        dec_if.in_valid = 1'b0;
        check("busy_latency", 128'(cyc - 1), 128'd10);
        check("busy_pt", dec_if.pt, c1_pt);
        consume();

        // Reset in the middle of round 5.
        start_block(c1_ct, c1_key);
        repeat (5) @(negedge clk);
        check("mid_rnd", 128'(dbg_rnd), 128'd5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_out_valid", 128'(dec_if.out_valid), 128'd0);
        check("mid_busy", 128'(dec_if.busy), 128'd0);
        check("mid_pt", dec_if.pt, 128'd0);
        check("mid_in_ready", 128'(dec_if.in_ready), 128'd0);
        check("mid_state", 128'(dbg_state), 128'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        start_block(c1_ct, c1_key);
        run_to_done(lat);
        check("rerun_latency", 128'(lat), 128'd10);
        check("rerun_pt", dec_if.pt, c1_pt);
        consume();

        // Back-to-back with in_valid and out_ready held high.
        wait_ready("b2b_in_ready");
        dec_if.ct        = c1_ct;
        dec_if.key_last  = c1_key;
        dec_if.in_valid  = 1'b1;
        dec_if.out_ready = 1'b1;
        @(negedge clk);
        dec_if.ct       = b_ct;
        dec_if.key_last = b_key;
        cyc = 1;
        n1  = 0;
        n2  = 0;
        while (n2 == 0 && cyc < 80) begin
            if (dec_if.out_valid === 1'b1) begin
                if (n1 == 0) begin
                    n1 = cyc;
                    check("b2b_first_pt", dec_if.pt, c1_pt);
                    check("b2b_no_overlap", 128'(dec_if.in_ready), 128'd0);
                end else begin
                    n2 = cyc;
                    check("b2b_second_pt", dec_if.pt, b_pt);
                end
            end
            if (n1 != 0 && dec_if.busy === 1'b1) dec_if.in_valid = 1'b0;
            if (n2 == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b2b_first_latency", 128'(n1 - 1), 128'd10);
        check("b2b_spacing", 128'(n2 - n1), 128'd12);
        dec_if.in_valid = 1'b0;
        @(negedge clk);
        dec_if.out_ready = 1'b0;

        // Random blocks from the forward-cipher model.
        for (int t = 0; t < 8; t++) begin
            r_p = rand128();
            r_k = rand128();
            aes_encrypt(r_p, r_k, r_c, r_rk);
            start_block(r_c, r_rk);
            run_to_done(lat);
            check("rnd_latency", 128'(lat), 128'd10);
            bp = $urandom_range(0, 3);
            repeat (bp) @(negedge clk);
            check("rnd_pt", dec_if.pt, r_p);
            check("rnd_key0", dbg_key, r_k);
            consume();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
